// File: rtl/rv32i_types.sv
// rv32i_types: shared out-of-order core types and CDB arbiter constants
// Holds ooo_instr_t (completed instruction), wb_bus_t (CDB broadcast),
// the CDB requester count and the per-unit request indices.
package rv32i_types;
  localparam int ROB_NUM_BITS = 4;
  localparam int NUM_CDB_REQ = 5;
  typedef logic [$clog2(NUM_CDB_REQ)-1:0] cdb_req_idx_t;
  localparam cdb_req_idx_t CDB_ALU = 3'd0;
  localparam cdb_req_idx_t CDB_MEM = 3'd1;
  localparam cdb_req_idx_t CDB_BR  = 3'd2;
  localparam cdb_req_idx_t CDB_MUL = 3'd3;
  localparam cdb_req_idx_t CDB_DIV = 3'd4;
  typedef struct packed {
    logic [31:0]             pc;
    logic [ROB_NUM_BITS-1:0] rob_addr;
    logic [4:0]              rd_addr;
    logic [5:0]              rd_paddr;
    logic [31:0]             rd_data;
  } ooo_instr_t;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [5:0]  rd_paddr;
    logic [31:0] rd_data;
  } wb_bus_t;
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder
// Ports: req (request vector), ptr (highest-priority index),
// gnt (one-hot grant), idx (grant index), any (some request granted).
module rr_pick #(
  parameter int N = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: fair common-data-bus arbiter with one holding slot per unit
// Ports: clk, rst (sync, active-high), flush; req_valid/req_instr/req_ready
// per functional unit (ALU=0 MEM=1 BR=2 MUL=3 DIV=4); registered outputs
// instr_out (CDB broadcast), wb_instr_struct, push_status, rob_addr.
// Macro CDB_ARB_STARVE_EN builds wait counters and the starvation override.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  ooo_instr_t              req_instr [NUM_REQ],
  output logic [NUM_REQ-1:0]      req_ready,
  output wb_bus_t                 instr_out,
  output ooo_instr_t              wb_instr_struct,
  output logic                    push_status,
  output logic [ROB_NUM_BITS-1:0] rob_addr
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end
  logic [NUM_REQ-1:0] full, xfer, rot_gnt, gnt;
  logic [IW-1:0] ptr, rot_idx, idx;
  logic rot_any, any;
  ooo_instr_t slot [NUM_REQ];
  ooo_instr_t win;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(full),
    .ptr(ptr),
    .gnt(rot_gnt),
    .idx(rot_idx),
    .any(rot_any)
  );
`ifdef CDB_ARB_STARVE_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);
  logic [WW-1:0] wait_cnt [NUM_REQ];
  // Scanning downward lets the lowest-index starved slot overwrite the others.
  always_comb begin
    gnt = rot_gnt;
    idx = rot_idx;
    any = rot_any;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (full[i] && wait_cnt[i] == LIM) begin
        gnt = '0;
        gnt[i] = 1'b1;
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_cnt[i] <= (rst || flush || xfer[i] || gnt[i]) ? '0 :
                     (full[i] && wait_cnt[i] != LIM) ? wait_cnt[i] + 1'b1 : wait_cnt[i];
    end
  end
`else
  assign gnt = rot_gnt;
  assign idx = rot_idx;
  assign any = rot_any;
`endif
  // A slot granted this cycle is free again at the same edge, so it may refill.
  assign req_ready = {NUM_REQ{~rst & ~flush}} & (~full | gnt);
  assign xfer = req_valid & req_ready;
  assign win = slot[idx];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer[i]) slot[i] <= req_instr[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      full <= '0;
      ptr <= '0;
      instr_out <= '0;
      wb_instr_struct <= '0;
      push_status <= 1'b0;
      rob_addr <= '0;
    end else begin
      full <= xfer | (full & ~gnt);
      if (any) ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      instr_out.valid <= any;
      instr_out.rd_addr <= any ? win.rd_addr : '0;
      instr_out.rd_paddr <= any ? win.rd_paddr : '0;
      instr_out.rd_data <= any ? win.rd_data : '0;
      wb_instr_struct <= any ? win : '0;
      push_status <= any;
      rob_addr <= any ? win.rob_addr : '0;
    end
  end
endmodule
